// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port SPRAM between the CPU pipeline
// (port A, priority) and a secondary bus master (port B). At most one access
// reaches the memory per cycle. A bounded-starvation counter forces a B grant
// after MAX_GRANTS consecutive A grants while B waits. Read data returns one
// cycle after the grant, tagged to the port that issued the read.
module spram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_GRANTS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  a_req,
  input  logic                  a_wren,
  input  logic [3:0]            a_wmask,
  input  logic [31:0]           a_wdata,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,

  input  logic                  b_req,
  input  logic                  b_wren,
  input  logic [3:0]            b_wmask,
  input  logic [31:0]           b_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,

  output logic                  mem_wren,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = (MAX_GRANTS < 1) ? 1 : $clog2(MAX_GRANTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANTS);

  // Number of A grants B has sat through since it last got the memory.
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;

  // {a_pend, b_pend}: which port owns the read data arriving next cycle.
  logic [1:0] rd_owner;
  logic [1:0] rd_owner_nxt;
  logic       a_pend;
  logic       b_pend;

  logic       b_turn;

  assign b_turn = (starve_cnt == CNT_MAX);

  // Grant decision: A wins contention unless B has waited MAX_GRANTS grants.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rstn) begin
      if (a_req && b_req) begin
        if (b_turn) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Memory port mux: granted port drives the SPRAM, idle cycles park on port A
  // with writes and byte lanes disabled.
  always_comb begin
    mem_addr  = a_addr;
    mem_wdata = a_wdata;
    mem_wren  = 1'b0;
    mem_wmask = '0;
    if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_wren  = b_wren;
      mem_wmask = b_wren ? b_wmask : '0;
    end else if (a_gnt) begin
      mem_wren  = a_wren;
      mem_wmask = a_wren ? a_wmask : '0;
    end
  end

  // Starvation counter next state: clears when B is served or stops asking,
  // counts A grants taken while B waits, saturating at MAX_GRANTS.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!b_req || b_gnt) begin
      starve_cnt_nxt = '0;
    end else if (a_gnt && (starve_cnt != CNT_MAX)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Read ownership for the next cycle: set only by a read grant.
  always_comb begin
    rd_owner_nxt = {a_gnt & ~a_wren, b_gnt & ~b_wren};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
      rd_owner   <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      rd_owner   <= rd_owner_nxt;
    end
  end

  assign {a_pend, b_pend} = rd_owner;

  // Read return: data is shared, rvalid says which port it belongs to.
  assign a_rvalid = a_pend;
  assign b_rvalid = b_pend;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of arbitration and memory.
module tb_spram_arbiter;

  localparam int AW = 14;
  localparam int MG = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          a_req, a_wren, b_req, b_wren;
  logic [3:0]    a_wmask, b_wmask;
  logic [31:0]   a_wdata, b_wdata;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          mem_wren;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.ADDR_WIDTH(AW), .MAX_GRANTS(MG)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_wren(a_wren), .a_wmask(a_wmask), .a_wdata(a_wdata),
    .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wren(b_wren), .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wren(mem_wren), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // SPRAM stand-in: byte-masked write, one-cycle registered read.
  bit [31:0] spram [16384];
  always @(posedge clk) begin
    if (mem_wren)
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) spram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= spram[mem_addr];
  end

  // ---------------- reference model ----------------
  bit [31:0] ref_mem [16384];
  int        m_wait = 0;     // A grants B has waited through
  bit        m_pa = 1'b0, m_pb = 1'b0;
  bit [31:0] m_pdata = '0;
  logic      eg_a, eg_b;

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d,
                                      input bit [3:0] m);
    bit [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // B is served when alone, or once it has waited MG A grants.
  assign eg_b = (rstn === 1'b1) && b_req && (!a_req || (m_wait >= MG));
  assign eg_a = (rstn === 1'b1) && a_req && !eg_b;

  always @(posedge clk) begin
    m_pa    <= eg_a && !a_wren;
    m_pb    <= eg_b && !b_wren;
    m_pdata <= eg_b ? ref_mem[b_addr] : ref_mem[a_addr];
    if (eg_a && a_wren) ref_mem[a_addr] <= merge(ref_mem[a_addr], a_wdata, a_wmask);
    if (eg_b && b_wren) ref_mem[b_addr] <= merge(ref_mem[b_addr], b_wdata, b_wmask);
    if ((rstn !== 1'b1) || !b_req || eg_b) m_wait <= 0;
    else if (eg_a) m_wait <= m_wait + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 1'b0;
    b_req = 1'b0;
    a_wren = 1'b0;
    b_wren = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_wren = 1'b0; b_wren = 1'b0;
    a_wmask = 4'hF; b_wmask = 4'hF; a_addr = '0; b_addr = '0;
    a_wdata = '0; b_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt} !== 2'b00) begin
        errors++; $display("FAIL reset_gnt cyc%0d: got %b expected 00", i, {a_gnt, b_gnt});
      end
      checks++;
      if (mem_wmask !== 4'h0 || mem_wren !== 1'b0) begin
        errors++; $display("FAIL reset_mem cyc%0d: got wren=%b wmask=%h expected 0/0", i, mem_wren, mem_wmask);
      end
      step();
    end
    rstn = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_release_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
    end
    step();
  endtask

  task automatic test_single_read();
    a_req = 1'b1; a_wren = 1'b1; a_wmask = 4'hF; a_wdata = 32'hDEADBEEF; a_addr = 14'h0005;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || mem_wren !== 1'b1) begin
      errors++; $display("FAIL preload_write: got gnt=%b wren=%b expected 1/1", a_gnt, mem_wren);
    end
    step();
    a_wren = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++; $display("FAIL single_rd_gnt: got a=%b b=%b expected 1/0", a_gnt, b_gnt);
    end
    checks++;
    if (mem_addr !== 14'h0005 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL single_rd_mem: got addr=%h wmask=%h expected 0005/0", mem_addr, mem_wmask);
    end
    checks++;
    if (a_rvalid !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid: got %b expected 0", a_rvalid);
    end
    step();
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_rd_data: got v=%b d=%h expected 1/deadbeef", a_rvalid, a_rdata);
    end
    checks++;
    if (b_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_rd_b_rvalid: got %b expected 0", b_rvalid);
    end
    step();
  endtask

  task automatic test_masked_write();
    a_req = 1'b1; a_wren = 1'b1; a_wmask = 4'hF; a_wdata = 32'hAABBCCDD; a_addr = 14'h3FFF;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++; $display("FAIL mw_preload_gnt: got %b expected 1", a_gnt);
    end
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_wren = 1'b1; b_wmask = 4'b0011; b_wdata = 32'h12345678; b_addr = 14'h3FFF;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      errors++; $display("FAIL mw_gnt: got a=%b b=%b expected 0/1", a_gnt, b_gnt);
    end
    checks++;
    if (mem_wren !== 1'b1 || mem_wmask !== 4'b0011 || mem_addr !== 14'h3FFF || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL mw_mem: got wren=%b wmask=%b addr=%h wdata=%h expected 1/0011/3fff/12345678",
                         mem_wren, mem_wmask, mem_addr, mem_wdata);
    end
    step();
    // zero-mask write: granted, touches nothing
    b_wmask = 4'b0000; b_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      errors++; $display("FAIL mw_no_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
    end
    checks++;
    if (b_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_wmask !== 4'b0000) begin
      errors++; $display("FAIL zero_mask_write: got gnt=%b wren=%b wmask=%b expected 1/1/0000", b_gnt, mem_wren, mem_wmask);
    end
    step();
    b_wren = 1'b0;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1) begin
      errors++; $display("FAIL mw_read_gnt: got %b expected 1", b_gnt);
    end
    step();
    b_req = 1'b0;
    @(negedge clk);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'hAABB5678 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL mw_readback: got bv=%b d=%h av=%b expected 1/aabb5678/0", b_rvalid, b_rdata, a_rvalid);
    end
    step();
  endtask

  task automatic test_starvation();
    bit pa = 1'b0, pb = 1'b0, exp_b;
    a_req = 1'b1; a_wren = 1'b0; a_addr = 14'h0005;
    b_req = 1'b1; b_wren = 1'b0; b_addr = 14'h3FFF;
    for (int i = 0; i < 15; i++) begin
      exp_b = ((i % (MG + 1)) == MG);
      @(negedge clk);
      checks++;
      if (a_gnt !== !exp_b || b_gnt !== exp_b) begin
        errors++; $display("FAIL starve_seq cyc%0d: got a=%b b=%b expected %b/%b", i, a_gnt, b_gnt, !exp_b, exp_b);
      end
      checks++;
      if (a_rvalid !== pa || b_rvalid !== pb) begin
        errors++; $display("FAIL starve_rvalid cyc%0d: got a=%b b=%b expected %b/%b", i, a_rvalid, b_rvalid, pa, pb);
      end
      if (pa) begin
        checks++;
        if (a_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL starve_a_data cyc%0d: got %h expected deadbeef", i, a_rdata);
        end
      end
      if (pb) begin
        checks++;
        if (b_rdata !== 32'hAABB5678) begin
          errors++; $display("FAIL starve_b_data cyc%0d: got %h expected aabb5678", i, b_rdata);
        end
      end
      pa = !exp_b;
      pb = exp_b;
      step();
    end
    idle();
    @(negedge clk);
    checks++;
    if (a_rvalid !== pa || b_rvalid !== pb) begin
      errors++; $display("FAIL starve_tail_rvalid: got a=%b b=%b expected %b/%b", a_rvalid, b_rvalid, pa, pb);
    end
    step();
  endtask

  task automatic test_counter_clear();
    bit exp_b;
    a_req = 1'b1; a_wren = 1'b0; a_addr = 14'h0005;
    b_req = 1'b1; b_wren = 1'b0; b_addr = 14'h3FFF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) b_req = 1'b0;
      @(negedge clk);
      checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
        errors++; $display("FAIL clr_pre cyc%0d: got a=%b b=%b expected 1/0", i, a_gnt, b_gnt);
      end
      step();
    end
    b_req = 1'b1;
    for (int j = 0; j <= MG; j++) begin
      exp_b = (j == MG);
      @(negedge clk);
      checks++;
      if (a_gnt !== !exp_b || b_gnt !== exp_b) begin
        errors++; $display("FAIL clr_wait cyc%0d: got a=%b b=%b expected %b/%b", j, a_gnt, b_gnt, !exp_b, exp_b);
      end
      step();
      if (exp_b) b_req = 1'b0;
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    bit        t_b    [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit        t_wr   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit [13:0] t_addr [7] = '{14'h40, 14'h41, 14'h41, 14'h40, 14'h40, 14'h40, 14'h40};
    bit [31:0] t_data [7] = '{32'h11111111, 32'h22222222, 32'h22222222, 32'h11111111,
                              32'h33333333, 32'h33333333, 32'h33333333};
    bit ev_a, ev_b;
    for (int i = 0; i <= 7; i++) begin
      idle();
      if (i < 7) begin
        if (t_b[i]) begin
          b_req = 1'b1; b_wren = t_wr[i]; b_wmask = 4'hF; b_addr = t_addr[i]; b_wdata = t_data[i];
        end else begin
          a_req = 1'b1; a_wren = t_wr[i]; a_wmask = 4'hF; a_addr = t_addr[i]; a_wdata = t_data[i];
        end
      end
      ev_a = (i > 0) && !t_wr[(i > 0) ? i-1 : 0] && !t_b[(i > 0) ? i-1 : 0];
      ev_b = (i > 0) && !t_wr[(i > 0) ? i-1 : 0] &&  t_b[(i > 0) ? i-1 : 0];
      @(negedge clk);
      if (i < 7) begin
        checks++;
        if (b_gnt !== t_b[i] || a_gnt !== !t_b[i]) begin
          errors++; $display("FAIL b2b_gnt op%0d: got a=%b b=%b expected %b/%b", i, a_gnt, b_gnt, !t_b[i], t_b[i]);
        end
      end
      checks++;
      if (a_rvalid !== ev_a || b_rvalid !== ev_b) begin
        errors++; $display("FAIL b2b_rvalid op%0d: got a=%b b=%b expected %b/%b", i, a_rvalid, b_rvalid, ev_a, ev_b);
      end
      if (ev_a || ev_b) begin
        checks++;
        if ((ev_a ? a_rdata : b_rdata) !== t_data[i-1]) begin
          errors++; $display("FAIL b2b_data op%0d: got %h expected %h", i, ev_a ? a_rdata : b_rdata, t_data[i-1]);
        end
      end
      step();
    end
    idle();
  endtask

  task automatic test_random();
    bit hold_a = 1'b0, hold_b = 1'b0;
    logic [3:0]    x_mask;
    logic [AW-1:0] x_addr;
    logic [31:0]   x_wdata;
    for (int n = 0; n < 400; n++) begin
      rstn = ($urandom_range(0, 59) != 0);
      if (!hold_a) begin
        a_req = ($urandom_range(0, 3) != 0); a_wren = 1'($urandom_range(0, 1));
        a_wmask = 4'($urandom); a_wdata = $urandom; a_addr = AW'($urandom_range(0, 15));
      end
      if (!hold_b) begin
        b_req = 1'($urandom_range(0, 1)); b_wren = 1'($urandom_range(0, 1));
        b_wmask = 4'($urandom); b_wdata = $urandom; b_addr = AW'($urandom_range(0, 15));
      end
      @(negedge clk);
      x_mask  = (eg_b && b_wren) ? b_wmask : ((eg_a && a_wren) ? a_wmask : 4'h0);
      x_addr  = eg_b ? b_addr : a_addr;
      x_wdata = eg_b ? b_wdata : a_wdata;
      checks++;
      if (a_gnt !== eg_a || b_gnt !== eg_b) begin
        errors++; $display("FAIL rnd_gnt n%0d: got a=%b b=%b expected %b/%b", n, a_gnt, b_gnt, eg_a, eg_b);
      end
      checks++;
      if (mem_wren !== ((eg_a && a_wren) || (eg_b && b_wren)) || mem_wmask !== x_mask ||
          mem_addr !== x_addr || mem_wdata !== x_wdata) begin
        errors++; $display("FAIL rnd_mem n%0d: got wren=%b wmask=%h addr=%h wdata=%h expected wmask=%h addr=%h wdata=%h",
                           n, mem_wren, mem_wmask, mem_addr, mem_wdata, x_mask, x_addr, x_wdata);
      end
      checks++;
      if (a_rvalid !== m_pa || b_rvalid !== m_pb) begin
        errors++; $display("FAIL rnd_rvalid n%0d: got a=%b b=%b expected %b/%b", n, a_rvalid, b_rvalid, m_pa, m_pb);
      end
      if (m_pa || m_pb) begin
        checks++;
        if ((m_pa ? a_rdata : b_rdata) !== m_pdata) begin
          errors++; $display("FAIL rnd_rdata n%0d: got %h expected %h", n, m_pa ? a_rdata : b_rdata, m_pdata);
        end
      end
      hold_a = a_req && !eg_a;
      hold_b = b_req && !eg_b;
      step();
    end
    rstn = 1'b1;
    idle();
    step();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1'b1; a_wren = 1'b0; a_addr = 14'h0005;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++; $display("FAIL rmr_gnt: got %b expected 1", a_gnt);
    end
    step();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL rmr_reset_gnt: got gnt=%b wmask=%h expected 0/0", a_gnt, mem_wmask);
    end
    step();
    rstn = 1'b1;
    a_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
        errors++; $display("FAIL rmr_rvalid cyc%0d: got %b expected 00", i, {a_rvalid, b_rvalid});
      end
      step();
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    a_wmask = '0; b_wmask = '0; a_wdata = '0; b_wdata = '0; a_addr = '0; b_addr = '0;
    test_reset();
    test_single_read();
    test_masked_write();
    test_starvation();
    test_counter_clear();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter that shares the single-port main SPRAM between the CPU pipeline (port A) and a secondary bus master such as a UART loader or DMA engine (port B). At most one access reaches the memory per cycle. Port A has priority, and a bounded-starvation counter guarantees port B forward progress. The block sits between the requesters and the SPRAMMemory instance, and returns read data with the memory's one-cycle latency tagged to the port that issued the read.

## Interface
Parameters:
- ADDR_WIDTH, default 14: word-address width, matching the SPRAM address port.
- MAX_GRANTS, default 4: maximum consecutive A grants while B is waiting; legal range is at least 1, and 1 gives strict alternation.

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  reset, synchronous, active-low.
- a_req  in  1  port A access request.
- a_wren  in  1  port A write (1) or read (0).
- a_wmask  in  4  port A byte-write mask (bit n = byte n).
- a_wdata  in  32  port A write data.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  32  port A read data.
- b_req, b_wren, b_wmask, b_wdata, b_addr  in  1/1/4/32/ADDR_WIDTH  port B request; same meaning as port A.
- b_gnt, b_rvalid, b_rdata  out  1/1/32  port B grant and read return.
- mem_wren  out  1  memory write enable.
- mem_wmask  out  4  memory byte mask.
- mem_wdata  out  32  memory write data.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_rdata  in  32  memory read data, valid the cycle after the address is presented.

## Operation
- A transfer occurs when req and gnt are both high in the same cycle. A requester holds req and its payload stable until it sees gnt.
- Grant decision is combinational each cycle:
  - When rstn=0, both grants are 0.
  - Otherwise, if only one port requests, that port is granted.
  - If both ports request, B is granted when starve_cnt == MAX_GRANTS; otherwise A is granted.
- starve_cnt is a register of width clog2(MAX_GRANTS+1).
  - Reset value is 0.
  - It increments when A is granted while b_req=1.
  - It clears when B is granted or when b_req=0.
  - It never exceeds MAX_GRANTS.
- Memory outputs:
  - mem_addr, mem_wdata, mem_wren and mem_wmask are driven by the granted port.
  - mem_wmask is forced to 0 when the grant is a read.
  - When no port is granted, mem_wren=0, mem_wmask=0, and mem_addr/mem_wdata follow port A.
- Read return:
  - rd_owner is a 2-bit register {a_pend, b_pend}. It is set on the cycle of a read grant and cleared otherwise.
  - a_rvalid = a_pend and b_rvalid = b_pend.
  - a_rdata and b_rdata both pass mem_rdata through; each is meaningful only while its rvalid is high.
- Writes produce no rvalid.
- A write with wmask=0 is granted normally and changes no memory bytes.
- Reset mid-operation: a read granted in the cycle where rstn is sampled low produces no rvalid. rd_owner and starve_cnt are 0 on the cycle after any cycle with rstn=0.
- Reset values: starve_cnt=0, rd_owner=0, a_rvalid=0, b_rvalid=0. a_gnt, b_gnt, mem_wren and mem_wmask are 0 throughout reset.

## Timing
- Grant latency is 0 cycles: gnt rises in the same cycle as req when the port wins.
- Read latency is 1 cycle: rvalid is high exactly the cycle after the read grant.
- Throughput is one access per cycle. Back-to-back grants alternating between ports, or mixing reads and writes, return data in grant order with no bubbles.
- Worst-case B wait under continuous A traffic is MAX_GRANTS cycles. The B grant occurs on cycle MAX_GRANTS+1 after b_req rises.
- Combinational path: req to gnt to mem_* outputs. There is no path from mem_rdata to any grant.

## Test plan
- Reset: hold rstn=0 for 3 cycles with a_req=b_req=1 (reads). Required: a_gnt=b_gnt=0 and mem_wmask=0 throughout; no rvalid on the first cycle after release.
- Single read: with A only, read addr 0x0005 while memory holds 0xDEADBEEF. Required: a_gnt in the same cycle, mem_addr=0x0005, and on the next cycle a_rvalid=1 with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Starvation bound: with MAX_GRANTS=4, hold a_req and b_req continuously (reads). Required: grant sequence A,A,A,A,B repeating, and each rvalid lands on the correct port one cycle after its grant.
- Masked write from B: B writes 0x12345678 with mask 0b0011 to addr 0x3FFF while A is idle. Required: b_gnt=1, mem_wren=1, mem_wmask=0b0011, mem_addr=0x3FFF, and no rvalid on either port. A subsequent read returns the upper bytes unchanged and the lower halfword 0x5678.
- Counter clear: hold a_req=1, raise b_req for 2 A grants, drop b_req for 1 cycle, then re-raise it. Required: starve_cnt returns to 0, and B waits a full 4 A grants before its grant.
- Reset mid-read: A read is granted, then rstn=0 in the following cycle. Required: a_rvalid=0 the cycle after reset is sampled; no spurious rvalid after rstn returns to 1.
